// File: rtl/ddr5_dimm_responder_pkg.sv
// Shared command/violation types and default DDR5 timing values
// for the DIMM-side responder.
package timing_parameters;
    localparam int tRCD   = 16;
    localparam int tCAS   = 16;
    localparam int tCWL   = 14;
    localparam int tBURST = 8;
    localparam int tWR    = 24;
    localparam int tRP    = 16;
endpackage

package ddr_cmd_pkg;
    typedef enum logic [2:0] {
        CMD_ACT0, CMD_ACT1, CMD_RD0, CMD_RD1, CMD_WR0, CMD_WR1, CMD_PRE
    } cmd_e;

    typedef enum logic [2:0] {
        V_NONE, V_HALF, V_BANK, V_ROW, V_TIMING, V_DATA
    } viol_e;

    typedef enum logic {B_CLOSED, B_OPEN} bank_state_e;

    typedef enum logic [2:0] {K_NONE, K_ACT, K_RD, K_WR, K_PRE} kind_e;

    // Kind of command that a latched first half will commit as.
    function automatic kind_e first_kind(input cmd_e c);
        case (c)
            CMD_RD0: return K_RD;
            CMD_WR0: return K_WR;
            default: return K_ACT;
        endcase
    endfunction
endpackage

// File: rtl/ddr5_dimm_responder_bank_tracker.sv
// Per-bank state: open/closed, open row, last committed kind and
// cycles elapsed since that commit (saturating).
module ddr_bank_tracker
    import ddr_cmd_pkg::*;
#(
    parameter int ROW_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             commit,
    input  kind_e            commit_kind,
    input  logic [ROW_W-1:0] commit_row,
    output bank_state_e      state,
    output logic [ROW_W-1:0] row,
    output kind_e            last_kind,
    output logic [7:0]       t_since,
    output logic             closed_ok,
    output logic             open_ok
);
    assign closed_ok = (state == B_CLOSED);
    assign open_ok   = (state == B_OPEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= B_CLOSED;
            row       <= '0;
            last_kind <= K_NONE;
            t_since   <= 8'hFF;
        end else if (commit) begin
            last_kind <= commit_kind;
            t_since   <= 8'd0;
            if (commit_kind == K_ACT) begin
                state <= B_OPEN;
                row   <= commit_row;
            end else if (commit_kind == K_PRE) begin
                state <= B_CLOSED;
            end
        end else if (t_since != 8'hFF) begin
            t_since <= t_since + 8'd1;
        end
    end
endmodule

// File: rtl/ddr5_dimm_responder.sv
// DDR5 DIMM responder: pairs command halves, checks bank/timing rules,
// drives data windows. RESP_STATS_EN builds the command counters.
module ddr5_dimm_responder
    import ddr_cmd_pkg::*;
    import timing_parameters::*;
#(
    parameter int NUM_BG  = 8,
    parameter int NUM_BA  = 4,
    parameter int ROW_W   = 16,
    parameter int COL_W   = 10,
    parameter int T_RCD   = tRCD,
    parameter int T_CAS   = tCAS,
    parameter int T_CWL   = tCWL,
    parameter int T_BURST = tBURST,
    parameter int T_WR    = tWR,
    parameter int T_RP    = tRP
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    input  cmd_e                        cmd_code,
    input  logic [$clog2(NUM_BG)-1:0]   cmd_bg,
    input  logic [$clog2(NUM_BA)-1:0]   cmd_ba,
    input  logic [ROW_W-1:0]            cmd_row,
    input  logic [COL_W-1:0]            cmd_col,
    output logic                        rd_data_valid,
    output logic                        wr_data_ready,
    output logic                        viol_valid,
    output viol_e                       viol_code,
    output logic [NUM_BG*NUM_BA-1:0]    bank_open,
    output logic [3:0][15:0]            stat_cnt
);
    localparam int NB  = NUM_BG * NUM_BA;
    localparam int BGW = $clog2(NUM_BG);
    localparam int BAW = $clog2(NUM_BA);
    localparam int BIW = BGW + BAW;

    // Elapsed cycles are t_since+1: a command N cycles after a commit sees N.
    localparam logic [8:0] RCD9 = 9'(T_RCD);
    localparam logic [8:0] RP9  = 9'(T_RP);
    localparam logic [8:0] PRD9 = 9'(T_CAS + T_BURST);
    localparam logic [8:0] PWR9 = 9'(T_CWL + T_BURST + T_WR);
    localparam logic [7:0] RD_LO = 8'(T_CAS + 1);
    localparam logic [7:0] RD_HI = 8'(T_CAS + T_BURST);
    localparam logic [7:0] WR_LO = 8'(T_CWL + 1);
    localparam logic [7:0] WR_HI = 8'(T_CWL + T_BURST);

    typedef enum logic {P_IDLE, P_HALF1} pair_e;

    pair_e             pst;
    logic              at_gap2;
    cmd_e              h_code;
    logic [BGW-1:0]    h_bg;
    logic [BAW-1:0]    h_ba;
    logic [ROW_W-1:0]  h_row;
    logic [COL_W-1:0]  h_col;

    logic [BIW-1:0]    idx;
    logic [NB-1:0]     closed_ok, open_ok;
    bank_state_e       b_state [NB];
    logic [ROW_W-1:0]  b_row   [NB];
    kind_e             b_kind  [NB];
    logic [7:0]        b_t     [NB];

    logic [8:0]        elapsed;
    logic              act_t_ok, acc_t_ok, pre_t_ok, pair_match;
    viol_e             act_v, acc_v, pre_v, viol_nxt;
    logic              commit_en, start_half;
    kind_e             commit_kind;
    logic [2:0]        nxt_code;

    logic              busy, is_rd;
    logic [7:0]        dcnt;

    assign idx     = {cmd_bg, cmd_ba};
    assign elapsed = {1'b0, b_t[idx]} + 9'd1;

    assign act_t_ok = (b_kind[idx] != K_PRE) || (elapsed >= RP9);
    assign acc_t_ok = (b_kind[idx] != K_ACT) || (elapsed >= RCD9);
    assign pre_t_ok = (b_kind[idx] == K_RD) ? (elapsed >= PRD9) :
                      (b_kind[idx] == K_WR) ? (elapsed >= PWR9) : 1'b1;

    assign act_v = !closed_ok[idx] ? V_BANK :
                   act_t_ok ? V_NONE : V_TIMING;
    assign acc_v = !open_ok[idx] ? V_BANK :
                   (b_row[idx] != cmd_row) ? V_ROW :
                   acc_t_ok ? V_NONE : V_TIMING;
    assign pre_v = !open_ok[idx] ? V_BANK :
                   pre_t_ok ? V_NONE : V_TIMING;

    assign nxt_code   = h_code + 3'd1;
    assign pair_match = (cmd_code == nxt_code) && (cmd_bg == h_bg) &&
                        (cmd_ba == h_ba) && (cmd_row == h_row) &&
                        (cmd_col == h_col);

    always_comb begin
        viol_nxt    = V_NONE;
        commit_en   = 1'b0;
        commit_kind = K_NONE;
        start_half  = 1'b0;
        case (pst)
            P_IDLE: if (cmd_valid) begin
                unique case (cmd_code)
                    CMD_ACT0: begin
                        viol_nxt   = act_v;
                        start_half = (act_v == V_NONE);
                    end
                    CMD_RD0, CMD_WR0: begin
                        viol_nxt   = acc_v;
                        start_half = (acc_v == V_NONE);
                    end
                    CMD_ACT1, CMD_RD1, CMD_WR1: viol_nxt = V_HALF;
                    CMD_PRE: begin
                        viol_nxt    = pre_v;
                        commit_en   = (pre_v == V_NONE);
                        commit_kind = K_PRE;
                    end
                    default: ;
                endcase
            end
            P_HALF1: begin
                if (at_gap2 && cmd_valid && pair_match) begin
                    commit_en   = 1'b1;
                    commit_kind = first_kind(h_code);
                end else if (at_gap2 || cmd_valid) begin
                    viol_nxt = V_HALF;
                end
            end
            default: ;
        endcase
        // Bank state still commits; only the data window is refused.
        if (commit_en && busy &&
            (commit_kind == K_RD || commit_kind == K_WR))
            viol_nxt = V_DATA;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pst        <= P_IDLE;
            at_gap2    <= 1'b0;
            h_code     <= CMD_ACT0;
            h_bg       <= '0;
            h_ba       <= '0;
            h_row      <= '0;
            h_col      <= '0;
            viol_valid <= 1'b0;
            viol_code  <= V_NONE;
        end else begin
            viol_valid <= (viol_nxt != V_NONE);
            viol_code  <= viol_nxt;
            case (pst)
                P_IDLE: if (start_half) begin
                    pst     <= P_HALF1;
                    at_gap2 <= 1'b0;
                    h_code  <= cmd_code;
                    h_bg    <= cmd_bg;
                    h_ba    <= cmd_ba;
                    h_row   <= cmd_row;
                    h_col   <= cmd_col;
                end
                P_HALF1: begin
                    if (!at_gap2 && !cmd_valid) at_gap2 <= 1'b1;
                    else pst <= P_IDLE;
                end
                default: pst <= P_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            is_rd <= 1'b0;
            dcnt  <= 8'd0;
        end else if (commit_en && !busy &&
                     (commit_kind == K_RD || commit_kind == K_WR)) begin
            busy  <= 1'b1;
            is_rd <= (commit_kind == K_RD);
            dcnt  <= 8'd1;
        end else if (busy) begin
            dcnt <= dcnt + 8'd1;
            if (dcnt == (is_rd ? RD_HI : WR_HI)) busy <= 1'b0;
        end
    end

    assign rd_data_valid = busy && is_rd && dcnt >= RD_LO && dcnt <= RD_HI;
    assign wr_data_ready = busy && !is_rd && dcnt >= WR_LO && dcnt <= WR_HI;

    for (genvar i = 0; i < NB; i++) begin : g_bank
        ddr_bank_tracker #(.ROW_W(ROW_W)) u_bank (
            .clk         (clk),
            .rst_n       (rst_n),
            .commit      (commit_en && (idx == BIW'(i))),
            .commit_kind (commit_kind),
            .commit_row  (cmd_row),
            .state       (b_state[i]),
            .row         (b_row[i]),
            .last_kind   (b_kind[i]),
            .t_since     (b_t[i]),
            .closed_ok   (closed_ok[i]),
            .open_ok     (open_ok[i])
        );
        assign bank_open[i] = (b_state[i] == B_OPEN);
    end

`ifdef RESP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt <= '0;
        end else if (commit_en) begin
            case (commit_kind)
                K_ACT:   stat_cnt[3] <= stat_cnt[3] + 16'd1;
                K_RD:    stat_cnt[2] <= stat_cnt[2] + 16'd1;
                K_WR:    stat_cnt[1] <= stat_cnt[1] + 16'd1;
                K_PRE:   stat_cnt[0] <= stat_cnt[0] + 16'd1;
                default: ;
            endcase
        end
    end
`else
    assign stat_cnt = '0;
`endif
endmodule

// File: tb/tb_ddr5_dimm_responder.sv
// Scoreboard bench for ddr5_dimm_responder: directed command scenarios,
// expected data windows and violations queued, checked by a monitor.
module tb_ddr5_dimm_responder;
    import ddr_cmd_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cmd_valid = 1'b0;
    cmd_e            cmd_code = CMD_ACT0;
    logic [2:0]      cmd_bg = '0;
    logic [1:0]      cmd_ba = '0;
    logic [15:0]     cmd_row = '0;
    logic [9:0]      cmd_col = '0;
    logic            rd_data_valid, wr_data_ready, viol_valid;
    viol_e           viol_code;
    logic [31:0]     bank_open;
    logic [3:0][15:0] stat_cnt;

    ddr5_dimm_responder #(
        .T_RCD(4), .T_CAS(5), .T_CWL(3), .T_BURST(2), .T_WR(6), .T_RP(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid),
        .cmd_code(cmd_code), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba),
        .cmd_row(cmd_row), .cmd_col(cmd_col),
        .rd_data_valid(rd_data_valid), .wr_data_ready(wr_data_ready),
        .viol_valid(viol_valid), .viol_code(viol_code),
        .bank_open(bank_open), .stat_cnt(stat_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int base = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    localparam int EV_RD = 0, EV_WR = 1, EV_VIOL = 2;
    typedef struct {int t; int k; int c;} ev_t;
    ev_t q[$];

    task automatic expect_ev(input int t, input int k, input int c);
        ev_t e;
        e.t = base + t; e.k = k; e.c = c;
        q.push_back(e);
    endtask

    task automatic ev_chk(input int k, input int c);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d code=%0d at t=%0d",
                     k, c, cyc - base);
        end else begin
            e = q.pop_front();
            if (e.t != cyc || e.k != k || e.c != c) begin
                errors++;
                $display("FAIL event got kind=%0d code=%0d t=%0d want kind=%0d code=%0d t=%0d",
                         k, c, cyc - base, e.k, e.c, e.t - base);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_data_valid) ev_chk(EV_RD, 0);
            if (wr_data_ready) ev_chk(EV_WR, 0);
            if (viol_valid)    ev_chk(EV_VIOL, int'(viol_code));
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at t=%0d",
                     name, act, exp, cyc - base);
        end
    endtask

    function automatic logic [63:0] exp_stat(input int a, input int r,
                                             input int w, input int p);
        logic [63:0] v;
        v = {16'(a), 16'(r), 16'(w), 16'(p)};
`ifndef RESP_STATS_EN
        v = '0;
`endif
        return v;
    endfunction

    task automatic do_reset;
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic begin_scn;
        @(posedge clk);
        #1 base = cyc;
    endtask

    task automatic wait_to(input int t);
        while (cyc - base < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmd_at(input int t, input cmd_e c, input int bg,
                          input int ba, input logic [15:0] row,
                          input logic [9:0] col);
        wait_to(t);
        cmd_valid = 1'b1;
        cmd_code  = c;
        cmd_bg    = 3'(bg);
        cmd_ba    = 2'(ba);
        cmd_row   = row;
        cmd_col   = col;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        ev_t e;
        @(posedge clk);
        #1;
        check("rst_bank_open", 64'(bank_open), 64'd0);
        check("rst_outputs", {61'd0, rd_data_valid, wr_data_ready, viol_valid}, 64'd0);
        check("rst_stat", stat_cnt, 64'd0);
        do_reset;

        // Read: bg2 ba1 -> bank index 9
        begin_scn;
        expect_ev(14, EV_RD, 0);
        expect_ev(15, EV_RD, 0);
        cmd_at(0, CMD_ACT0, 2, 1, 16'h1A2B, 10'h000);
        check("rd_open_before_act1", 64'(bank_open), 64'd0);
        cmd_at(2, CMD_ACT1, 2, 1, 16'h1A2B, 10'h000);
        check("rd_open_after_act1", 64'(bank_open), 64'h200);
        cmd_at(6, CMD_RD0, 2, 1, 16'h1A2B, 10'h055);
        cmd_at(8, CMD_RD1, 2, 1, 16'h1A2B, 10'h055);
        wait_to(15);
        check("rd_open_at_15", 64'(bank_open[9]), 64'd1);
        cmd_at(15, CMD_PRE, 2, 1, 16'h1A2B, 10'h000);
        check("rd_closed_at_16", 64'(bank_open), 64'd0);
        wait_to(20);
        check("rd_stat", stat_cnt, exp_stat(1, 1, 0, 1));

        // Write with legal PRE at 19
        do_reset;
        begin_scn;
        expect_ev(12, EV_WR, 0);
        expect_ev(13, EV_WR, 0);
        cmd_at(0, CMD_ACT0, 2, 1, 16'h1A2B, 10'h000);
        cmd_at(2, CMD_ACT1, 2, 1, 16'h1A2B, 10'h000);
        cmd_at(6, CMD_WR0, 2, 1, 16'h1A2B, 10'h011);
        cmd_at(8, CMD_WR1, 2, 1, 16'h1A2B, 10'h011);
        cmd_at(19, CMD_PRE, 2, 1, 16'h1A2B, 10'h000);
        check("wr_closed_at_20", 64'(bank_open), 64'd0);
        wait_to(22);

        // Write with early PRE at 18, bg5 ba3 -> bank index 23
        do_reset;
        begin_scn;
        expect_ev(12, EV_WR, 0);
        expect_ev(13, EV_WR, 0);
        expect_ev(19, EV_VIOL, int'(V_TIMING));
        cmd_at(0, CMD_ACT0, 5, 3, 16'h0F0F, 10'h000);
        cmd_at(2, CMD_ACT1, 5, 3, 16'h0F0F, 10'h000);
        cmd_at(6, CMD_WR0, 5, 3, 16'h0F0F, 10'h020);
        cmd_at(8, CMD_WR1, 5, 3, 16'h0F0F, 10'h020);
        cmd_at(18, CMD_PRE, 5, 3, 16'h0F0F, 10'h000);
        wait_to(20);
        check("wr_early_pre_open", 64'(bank_open), 64'h0080_0000);
        wait_to(22);
        check("wr_stat", stat_cnt, exp_stat(1, 0, 1, 0));

        // Half-pairing violations
        do_reset;
        begin_scn;
        expect_ev(2, EV_VIOL, int'(V_HALF));
        expect_ev(7, EV_VIOL, int'(V_HALF));
        expect_ev(11, EV_VIOL, int'(V_HALF));
        expect_ev(16, EV_VIOL, int'(V_HALF));
        cmd_at(0, CMD_ACT0, 0, 2, 16'h0100, 10'h000);
        cmd_at(1, CMD_ACT1, 0, 2, 16'h0100, 10'h000);
        cmd_at(4, CMD_ACT0, 0, 2, 16'h0100, 10'h000);
        cmd_at(10, CMD_RD1, 0, 2, 16'h0100, 10'h000);
        cmd_at(13, CMD_ACT0, 0, 2, 16'h0100, 10'h000);
        cmd_at(15, CMD_PRE, 0, 2, 16'h0100, 10'h000);
        wait_to(18);
        check("half_bank_closed", 64'(bank_open), 64'd0);
        check("half_stat", stat_cnt, exp_stat(0, 0, 0, 0));

        // Bank/row/timing/data violations on bank 0
        do_reset;
        begin_scn;
        expect_ev(1, EV_VIOL, int'(V_BANK));
        expect_ev(8, EV_VIOL, int'(V_TIMING));
        expect_ev(10, EV_VIOL, int'(V_ROW));
        expect_ev(19, EV_VIOL, int'(V_DATA));
        expect_ev(20, EV_RD, 0);
        expect_ev(21, EV_RD, 0);
        cmd_at(0, CMD_RD0, 0, 0, 16'h1A2B, 10'h000);
        cmd_at(2, CMD_ACT0, 0, 0, 16'h1A2B, 10'h000);
        cmd_at(4, CMD_ACT1, 0, 0, 16'h1A2B, 10'h000);
        cmd_at(7, CMD_RD0, 0, 0, 16'h1A2B, 10'h000);
        cmd_at(9, CMD_RD0, 0, 0, 16'h1A2C, 10'h000);
        cmd_at(12, CMD_RD0, 0, 0, 16'h1A2B, 10'h003);
        cmd_at(14, CMD_RD1, 0, 0, 16'h1A2B, 10'h003);
        cmd_at(16, CMD_WR0, 0, 0, 16'h1A2B, 10'h004);
        cmd_at(18, CMD_WR1, 0, 0, 16'h1A2B, 10'h004);
        wait_to(25);
        check("chk_bank0_open", 64'(bank_open), 64'd1);
        check("chk_stat", stat_cnt, exp_stat(1, 1, 1, 0));

        // PRE -> ACT tRP boundary, bg3 ba2 -> bank index 14
        do_reset;
        begin_scn;
        expect_ev(14, EV_VIOL, int'(V_TIMING));
        expect_ev(21, EV_VIOL, int'(V_BANK));
        cmd_at(0, CMD_ACT0, 3, 2, 16'h7777, 10'h000);
        cmd_at(2, CMD_ACT1, 3, 2, 16'h7777, 10'h000);
        cmd_at(10, CMD_PRE, 3, 2, 16'h7777, 10'h000);
        cmd_at(13, CMD_ACT0, 3, 2, 16'h7777, 10'h000);
        cmd_at(14, CMD_ACT0, 3, 2, 16'h7777, 10'h000);
        cmd_at(16, CMD_ACT1, 3, 2, 16'h7777, 10'h000);
        check("trp_reopen", 64'(bank_open), 64'h4000);
        cmd_at(20, CMD_PRE, 1, 0, 16'h0000, 10'h000);
        wait_to(23);
        check("trp_stat", stat_cnt, exp_stat(2, 0, 0, 1));

        // Reset in the first beat of a read burst
        do_reset;
        begin_scn;
        cmd_at(0, CMD_ACT0, 2, 1, 16'h1A2B, 10'h000);
        cmd_at(2, CMD_ACT1, 2, 1, 16'h1A2B, 10'h000);
        cmd_at(6, CMD_RD0, 2, 1, 16'h1A2B, 10'h055);
        cmd_at(8, CMD_RD1, 2, 1, 16'h1A2B, 10'h055);
        wait_to(14);
        check("rst_mid_window_before", 64'(rd_data_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_rd_valid", 64'(rd_data_valid), 64'd0);
        check("rst_mid_bank_open", 64'(bank_open), 64'd0);
        check("rst_mid_stat", stat_cnt, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        while (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event kind=%0d code=%0d abs_cycle=%0d",
                     e.k, e.c, e.t);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
